ps2_host_transmitter: RTL and testbench

PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

---
 rtl/ps2_host_transmitter.sv | 165 ++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter.
// Inhibits the clock, issues a request-to-send, and then shifts out one byte
// with odd parity on the device-generated clock. It finishes by checking the
// device acknowledge.
module ps2_host_transmitter #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES         = 10,
  parameter int START_TIMEOUT      = 750000,
  parameter int XFER_TIMEOUT       = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int MAX_A = (CLK_INHIBIT_CYCLES > RTS_CYCLES) ? CLK_INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_B = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] INH_LIM   = CNT_W'(CLK_INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] RTS_LIM   = CNT_W'(RTS_CYCLES);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_CLK, SEND, COMPLETE, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             par_q, par_d;
  logic             dat_q, dat_d;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic clk_fall;

  // Synchronise the raw pins; lines idle high, so reset to 1 to avoid a false edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;
  assign cnt_inc  = cnt_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      par_q   <= 1'b0;
      dat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      par_q   <= par_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic: phase timing, bit sequencing and timeouts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    par_d   = par_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (send_command) begin
          cmd_d   = command;
          par_d   = ~^command;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_inc == INH_LIM) begin
          cnt_d   = '0;
          state_d = RTS;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RTS: begin
        if (cnt_inc == RTS_LIM) begin
          cnt_d   = '0;
          state_d = WAIT_CLK;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_CLK: begin
        if (clk_fall) begin
          bit_d   = 4'd1;
          dat_d   = ~cmd_q[0];
          cnt_d   = '0;
          state_d = SEND;
        end else if (cnt_inc == START_LIM) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SEND: begin
        // bit_q holds the number of falling edges already seen.
        if (clk_fall && bit_q == 4'd10) begin
          state_d = dat_s2 ? ERROR : COMPLETE;
        end else begin
          if (clk_fall) begin
            bit_d = bit_q + 4'd1;
            if (bit_q < 4'd8)       dat_d = ~cmd_q[bit_q[2:0]];
            else if (bit_q == 4'd8) dat_d = ~par_q;
            else                    dat_d = 1'b0;
          end
          if (cnt_inc == XFER_LIM) state_d = ERROR;
          else                     cnt_d   = cnt_inc;
        end
      end
      COMPLETE: state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Line drivers and status decoded from the registered state.
  always_comb begin
    ps2_clk_oe                    = (state_q == INHIBIT) || (state_q == RTS);
    ps2_dat_oe                    = (state_q == RTS) || (state_q == WAIT_CLK) ||
                                    ((state_q == SEND) && dat_q);
    busy                          = (state_q != IDLE);
    command_was_sent              = (state_q == COMPLETE);
    error_communication_timed_out = (state_q == ERROR);
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter with a behavioural keyboard on a wired-AND bus.
module tb_ps2_host_transmitter;

  localparam int INH  = 100;
  localparam int RTSC = 10;
  localparam int STO  = 300;
  localparam int XTO  = 1000;
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] command = '0;
  logic       send_command = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_communication_timed_out;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_transmitter #(
    .CLK_INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTSC),
    .START_TIMEOUT(STO),
    .XFER_TIMEOUT(XTO)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .command(command),
    .send_command(send_command),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy(busy),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (command_was_sent) done_cnt++;
    if (error_communication_timed_out) err_cnt++;
  end

  // Expected frame after the start bit: 8 data bits LSB first, odd parity, stop = 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b};
  endfunction

  task automatic issue(input logic [7:0] c);
    @(negedge CLOCK_50);
    command = c;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
    command = 8'($urandom);
  endtask

  task automatic measure_setup(output int inh, output int rts);
    inh = 0;
    rts = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < INH * 4) begin
      inh++;
      @(negedge CLOCK_50);
    end
    while (ps2_clk_oe && ps2_dat_oe && rts < RTSC * 4) begin
      rts++;
      @(negedge CLOCK_50);
    end
  endtask

  // Keyboard: waits for clock release, then generates nedges falling edges and
  // reads the line on each rising edge. Returns right after falling edge 11.
  task automatic kbd(input int nedges, input bit ack, output logic [9:0] bits,
                     output bit start_low, output bit ok);
    int w;
    bits = '0;
    start_low = 1'b0;
    ok = 1'b0;
    w = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && w < STO) begin
      w++;
      @(negedge CLOCK_50);
    end
    if (w >= STO) return;
    ok = 1'b1;
    start_low = (ps2_dat_in == 1'b0);
    for (int k = 1; k <= nedges; k++) begin
      if (k == 11) dev_dat_low = ack;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b1;
      if (k == 11) break;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = ps2_dat_in;
    end
  endtask

  task automatic wait_outcome(output bit got_done, output bit got_err,
                              output bit oe_zero, output bit busy_after);
    int c;
    c = 0;
    while (!command_was_sent && !error_communication_timed_out && c < 3000) begin
      c++;
      @(negedge CLOCK_50);
    end
    got_done = command_was_sent;
    got_err = error_communication_timed_out;
    oe_zero = !ps2_clk_oe && !ps2_dat_oe;
    @(negedge CLOCK_50);
    busy_after = busy;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  // Full acknowledged transfer of one byte with all framing checks.
  task automatic test_frame(input logic [7:0] c, input string name);
    int inh, rts, d0, e0;
    logic [9:0] bits;
    bit start_low, ok, gd, ge, oz, ba;
    d0 = done_cnt;
    e0 = err_cnt;
    issue(c);
    measure_setup(inh, rts);
    kbd(11, 1'b1, bits, start_low, ok);
    wait_outcome(gd, ge, oz, ba);
    total_cnt++; if (inh !== INH) $display("FAIL %s inhibit cycles got %0d want %0d", name, inh, INH); else pass_cnt++;
    total_cnt++; if (rts !== RTSC) $display("FAIL %s rts cycles got %0d want %0d", name, rts, RTSC); else pass_cnt++;
    total_cnt++; if ({ok, start_low} !== 2'b11) $display("FAIL %s start bit got %b want 11", name, {ok, start_low}); else pass_cnt++;
    total_cnt++; if (bits !== ref_frame(c)) $display("FAIL %s frame got %b want %b", name, bits, ref_frame(c)); else pass_cnt++;
    total_cnt++; if ({gd, ge, oz} !== 3'b101) $display("FAIL %s outcome done/err/oe0 got %b want 101", name, {gd, ge, oz}); else pass_cnt++;
    total_cnt++; if (ba !== 1'b0) $display("FAIL %s busy after pulse got %b want 0", name, ba); else pass_cnt++;
    total_cnt++; if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0)
      $display("FAIL %s pulse counts done %0d err %0d want 1 0", name, done_cnt - d0, err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    total_cnt++;
    if ({ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_communication_timed_out} !== 5'b0)
      $display("FAIL reset outputs got %b want 00000",
               {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_communication_timed_out});
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) test_frame(8'($urandom), "random");
  endtask

  task automatic test_no_clock();
    int inh, rts, w, d0, e0;
    bit oz;
    d0 = done_cnt;
    e0 = err_cnt;
    issue(8'($urandom));
    measure_setup(inh, rts);
    w = 0;
    while (!error_communication_timed_out && w < STO * 2) begin
      w++;
      @(negedge CLOCK_50);
    end
    oz = !ps2_clk_oe && !ps2_dat_oe;
    repeat (2) @(negedge CLOCK_50);
    total_cnt++; if (w !== STO) $display("FAIL start_timeout cycles got %0d want %0d", w, STO); else pass_cnt++;
    total_cnt++; if ({oz, busy} !== 2'b10) $display("FAIL start_timeout lines/busy got %b want 10", {oz, busy}); else pass_cnt++;
    total_cnt++; if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0)
      $display("FAIL start_timeout pulses err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_no_ack();
    int inh, rts, d0;
    logic [9:0] bits;
    bit start_low, ok, gd, ge, oz, ba;
    logic [7:0] c;
    c = 8'($urandom);
    d0 = done_cnt;
    issue(c);
    measure_setup(inh, rts);
    kbd(11, 1'b0, bits, start_low, ok);
    wait_outcome(gd, ge, oz, ba);
    total_cnt++; if (bits !== ref_frame(c)) $display("FAIL no_ack frame got %b want %b", bits, ref_frame(c)); else pass_cnt++;
    total_cnt++; if ({gd, ge, oz, ba} !== 4'b0110) $display("FAIL no_ack outcome got %b want 0110", {gd, ge, oz, ba}); else pass_cnt++;
    total_cnt++; if ((done_cnt - d0) !== 0) $display("FAIL no_ack done pulses got %0d want 0", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_xfer_timeout();
    int inh, rts, d0;
    logic [9:0] bits;
    bit start_low, ok, gd, ge, oz, ba;
    d0 = done_cnt;
    issue(8'($urandom));
    measure_setup(inh, rts);
    kbd(4, 1'b0, bits, start_low, ok);
    wait_outcome(gd, ge, oz, ba);
    total_cnt++; if ({gd, ge, oz, ba} !== 4'b0110) $display("FAIL xfer_timeout outcome got %b want 0110", {gd, ge, oz, ba}); else pass_cnt++;
    total_cnt++; if ((done_cnt - d0) !== 0) $display("FAIL xfer_timeout done pulses got %0d want 0", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int inh, rts;
    logic [9:0] bits;
    bit start_low, ok;
    issue(8'hED);
    measure_setup(inh, rts);
    kbd(5, 1'b0, bits, start_low, ok);
    dev_dat_low = 1'b0;
    #3 reset = 1'b1;
    #1;
    total_cnt++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000)
      $display("FAIL reset_mid async outputs got %b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
    else pass_cnt++;
    @(negedge CLOCK_50);
    reset = 1'b0;
    test_frame(8'hED, "after_reset");
  endtask

  task automatic test_back_to_back();
    int inh, rts, d0;
    logic [9:0] bits;
    bit start_low, ok, gd, ge, oz, ba;
    logic [7:0] c;
    c = 8'($urandom);
    d0 = done_cnt;
    issue(c);
    repeat (5) @(negedge CLOCK_50);
    command = ~c;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
    measure_setup(inh, rts);
    kbd(11, 1'b1, bits, start_low, ok);
    wait_outcome(gd, ge, oz, ba);
    repeat (INH) @(negedge CLOCK_50);
    total_cnt++; if (inh !== INH - 6) $display("FAIL ignored_send inhibit rest got %0d want %0d", inh, INH - 6); else pass_cnt++;
    total_cnt++; if (bits !== ref_frame(c)) $display("FAIL ignored_send frame got %b want %b", bits, ref_frame(c)); else pass_cnt++;
    total_cnt++; if ((done_cnt - d0) !== 1 || busy !== 1'b0)
      $display("FAIL ignored_send done pulses %0d busy %b want 1 0", done_cnt - d0, busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame(8'hED, "cmd_ed");
    test_frame(8'hF4, "cmd_f4");
    test_random();
    test_no_clock();
    test_no_ack();
    test_xfer_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
